mem_store_forward: RTL and testbench

Parametrised store-data forwarding unit for the MEM stage of the pipelined CPU. When a store in EX/MEM reads a register (Rt) that is being written back this cycle, or was written back in one of the last DEPTH-1 cycles but is not yet visible to the store's captured operand, it substitutes the youngest matching value. This generalises the single-entry load→store check to a DEPTH-entry writeback history and a selectable load-only/any-writeback mode. It also adds a forwarding-event counter for performance measurement.

---
 rtl/mem_store_forward_pkg.sv | 16 +
 rtl/mem_store_forward_fwd_hist_entry.sv | 49 ++++
 rtl/mem_store_forward.sv | 111 +++++++++++
 tb/tb_mem_store_forward.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_store_forward_pkg.sv
// ============================================================================
// Module      : mem_store_forward_pkg
// Description : Shared CPU constants for MEM-stage store-data forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_store_forward_pkg;

    localparam int         FWD_SRC_W  = 3;
    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam logic [FWD_SRC_W-1:0] FWD_SRC_WB = 3'd0;

endpackage

`default_nettype wire

// File: rtl/mem_store_forward_fwd_hist_entry.sv
// ============================================================================
// Module      : fwd_hist_entry
// Description : One {valid, rd, data} writeback history slot with load/hold/clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_hist_entry #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic              i_valid,
    input  logic [REG_W-1:0]  i_rd,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [REG_W-1:0]  o_rd,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [REG_W-1:0]  r_rd;
    logic [DATA_W-1:0] r_data;

    // Clear only drops the valid bit; stale rd/data are harmless once invalid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_rd    <= '0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
            r_rd    <= i_rd;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_rd    = r_rd;
    assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/mem_store_forward.sv
// ============================================================================
// Module      : mem_store_forward
// Description : Store-data forwarding from live WB plus a DEPTH-1 deep writeback
//               history, youngest-first priority, saturating event counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_store_forward
    import mem_store_forward_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_W     = 5,
    parameter int DEPTH     = 2,
    parameter bit LOAD_ONLY = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic                 i_wb_reg_write,
    input  logic                 i_wb_mem_read,
    input  logic [REG_W-1:0]     i_wb_rd,
    input  logic [DATA_W-1:0]    i_wb_data,
    input  logic                 i_mem_write,
    input  logic [REG_W-1:0]     i_mem_rt,
    input  logic [DATA_W-1:0]    i_mem_rt_data,
    output logic [DATA_W-1:0]    o_store_data,
    output logic                 o_forward,
    output logic [FWD_SRC_W-1:0] o_forward_src,
    output logic [CNT_W-1:0]     o_fwd_count
);

    localparam logic [REG_W-1:0] c_REG_ZERO = REG_W'(REG_ZERO);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    // Source 0 is the live WB input; sources 1..DEPTH-1 are history entries.
    logic [DEPTH-1:0]             w_src_valid;
    logic [DEPTH-1:0][REG_W-1:0]  w_src_rd;
    logic [DEPTH-1:0][DATA_W-1:0] w_src_data;
    logic [DEPTH-1:0]             w_src_hit;
    logic                         w_store_req;

    assign w_src_valid[0] = i_rst_n & i_wb_reg_write & (i_wb_rd != c_REG_ZERO)
                          & (!LOAD_ONLY | i_wb_mem_read);
    assign w_src_rd[0]    = i_wb_rd;
    assign w_src_data[0]  = i_wb_data;
    assign w_store_req    = i_rst_n & i_mem_write & (i_mem_rt != c_REG_ZERO);

    generate
        if (DEPTH > 1) begin : g_hist
            for (genvar k = 1; k < DEPTH; k++) begin : g_entry
                fwd_hist_entry #(
                    .DATA_W (DATA_W),
                    .REG_W  (REG_W)
                ) u_entry (
                    .i_clk   (i_clk),
                    .i_rst_n (i_rst_n),
                    .i_clear (i_flush),
                    .i_load  (!i_stall),
                    .i_valid (w_src_valid[k-1]),
                    .i_rd    (w_src_rd[k-1]),
                    .i_data  (w_src_data[k-1]),
                    .o_valid (w_src_valid[k]),
                    .o_rd    (w_src_rd[k]),
                    .o_data  (w_src_data[k])
                );
            end
        end
    endgenerate

    logic [DEPTH:0]                 w_chain_hit;
    logic [DEPTH:0][FWD_SRC_W-1:0]  w_chain_src;
    logic [DEPTH:0][DATA_W-1:0]     w_chain_data;

    assign w_chain_hit[DEPTH]  = 1'b0;
    assign w_chain_src[DEPTH]  = FWD_SRC_WB;
    assign w_chain_data[DEPTH] = i_mem_rt_data;

    // Chain runs oldest to youngest so the lowest-numbered hit overrides.
    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_prio
            assign w_src_hit[k]    = w_store_req & w_src_valid[k]
                                   & (w_src_rd[k] != c_REG_ZERO)
                                   & (w_src_rd[k] == i_mem_rt);
            assign w_chain_hit[k]  = w_src_hit[k] | w_chain_hit[k+1];
            assign w_chain_src[k]  = w_src_hit[k] ? FWD_SRC_W'(k) : w_chain_src[k+1];
            assign w_chain_data[k] = w_src_hit[k] ? w_src_data[k] : w_chain_data[k+1];
        end
    endgenerate

    assign o_forward     = w_chain_hit[0];
    assign o_forward_src = w_chain_src[0];
    assign o_store_data  = w_chain_data[0];

    logic [CNT_W-1:0] r_fwd_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fwd_count <= '0;
        end else if (!i_stall && w_chain_hit[0] && (r_fwd_count != c_CNT_MAX)) begin
            r_fwd_count <= r_fwd_count + CNT_W'(1);
        end
    end

    assign o_fwd_count = r_fwd_count;

endmodule

`default_nettype wire

// File: tb/tb_mem_store_forward.sv
// ============================================================================
// Module      : tb_mem_store_forward
// Description : Three parameterisations driven in parallel, checked every
//               cycle against a writeback-history model, plus literal pins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_store_forward;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush;
    logic        wr, mr, mw;
    logic [4:0]  wb_rd, rt;
    logic [31:0] wb_data, rtd;

    logic [31:0] o_sd  [3];
    logic        o_fw  [3];
    logic [2:0]  o_src [3];
    logic [15:0] o_cnt [3];
    logic [15:0] cnt_a, cnt_b;
    logic [1:0]  cnt_c;

    int vectors     = 0;
    int miscompares = 0;

    // Instance parameters: a = DEPTH3/load-only, b = DEPTH4/any-WB, c = DEPTH1/CNT_W2
    int M_DEPTH [3] = '{3, 4, 1};
    bit M_LO    [3] = '{1'b1, 1'b0, 1'b1};
    int M_CW    [3] = '{16, 16, 2};

    always #5 clk = ~clk;

    mem_store_forward #(.DATA_W(32), .REG_W(5), .DEPTH(3), .LOAD_ONLY(1'b1), .CNT_W(16)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush),
        .i_wb_reg_write(wr), .i_wb_mem_read(mr), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
        .i_mem_write(mw), .i_mem_rt(rt), .i_mem_rt_data(rtd),
        .o_store_data(o_sd[0]), .o_forward(o_fw[0]), .o_forward_src(o_src[0]), .o_fwd_count(cnt_a));

    mem_store_forward #(.DATA_W(32), .REG_W(5), .DEPTH(4), .LOAD_ONLY(1'b0), .CNT_W(16)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush),
        .i_wb_reg_write(wr), .i_wb_mem_read(mr), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
        .i_mem_write(mw), .i_mem_rt(rt), .i_mem_rt_data(rtd),
        .o_store_data(o_sd[1]), .o_forward(o_fw[1]), .o_forward_src(o_src[1]), .o_fwd_count(cnt_b));

    mem_store_forward #(.DATA_W(32), .REG_W(5), .DEPTH(1), .LOAD_ONLY(1'b1), .CNT_W(2)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush),
        .i_wb_reg_write(wr), .i_wb_mem_read(mr), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
        .i_mem_write(mw), .i_mem_rt(rt), .i_mem_rt_data(rtd),
        .o_store_data(o_sd[2]), .o_forward(o_fw[2]), .o_forward_src(o_src[2]), .o_fwd_count(cnt_c));

    assign o_cnt[0] = cnt_a;
    assign o_cnt[1] = cnt_b;
    assign o_cnt[2] = {14'd0, cnt_c};

    // Model: recent writebacks per instance, index 1 = youngest
    bit          m_v   [3][8];
    logic [4:0]  m_rd  [3][8];
    logic [31:0] m_d   [3][8];
    int          m_cnt [3];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear(int i, bit with_cnt);
        for (int k = 0; k < 8; k++) m_v[i][k] = 1'b0;
        if (with_cnt) m_cnt[i] = 0;
    endfunction

    function automatic void model_eval(int i, output bit f, output logic [2:0] s,
                                       output logic [31:0] d);
        f = 1'b0; s = 3'd0; d = rtd;
        if (!rst_n || !mw || rt == 5'd0) return;
        if (wr && wb_rd != 5'd0 && (!M_LO[i] || mr) && wb_rd == rt) begin
            f = 1'b1; d = wb_data; return;
        end
        for (int k = 1; k < M_DEPTH[i]; k++) begin
            if (m_v[i][k] && m_rd[i][k] != 5'd0 && m_rd[i][k] == rt) begin
                f = 1'b1; s = 3'(k); d = m_d[i][k]; return;
            end
        end
    endfunction

    always @(negedge rst_n) for (int i = 0; i < 3; i++) model_clear(i, 1'b1);

    always @(posedge clk) begin
        bit f; logic [2:0] s; logic [31:0] d;
        for (int i = 0; i < 3; i++) begin
            model_eval(i, f, s, d);
            if (!rst_n) begin
                model_clear(i, 1'b1);
            end else begin
                if (f && !stall && m_cnt[i] < ((1 << M_CW[i]) - 1)) m_cnt[i]++;
                if (flush) begin
                    model_clear(i, 1'b0);
                end else if (!stall) begin
                    for (int k = M_DEPTH[i] - 1; k >= 2; k--) begin
                        m_v[i][k] = m_v[i][k-1]; m_rd[i][k] = m_rd[i][k-1]; m_d[i][k] = m_d[i][k-1];
                    end
                    if (M_DEPTH[i] > 1) begin
                        m_v[i][1]  = wr && wb_rd != 5'd0 && (!M_LO[i] || mr);
                        m_rd[i][1] = wb_rd;
                        m_d[i][1]  = wb_data;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        bit f; logic [2:0] s; logic [31:0] d;
        for (int i = 0; i < 3; i++) begin
            model_eval(i, f, s, d);
            chk($sformatf("fwd[%0d]", i), 32'(o_fw[i]), 32'(f));
            chk($sformatf("src[%0d]", i), 32'(o_src[i]), 32'(s));
            chk($sformatf("data[%0d]", i), o_sd[i], d);
            chk($sformatf("cnt[%0d]", i), 32'(o_cnt[i]), 32'(m_cnt[i]));
        end
    end

    task automatic drv(bit w, bit m, logic [4:0] r, logic [31:0] dd,
                       bit s, logic [4:0] t, logic [31:0] td);
        wr = w; mr = m; wb_rd = r; wb_data = dd; mw = s; rt = t; rtd = td;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic pin(int i, string tag, bit f, logic [2:0] s, logic [31:0] d);
        chk($sformatf("%s.fwd[%0d]", tag, i), 32'(o_fw[i]), 32'(f));
        chk($sformatf("%s.src[%0d]", tag, i), 32'(o_src[i]), 32'(s));
        chk($sformatf("%s.data[%0d]", tag, i), o_sd[i], d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt0;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drv(1, 1, 5'd8, 32'h0000_AAAA, 1, 5'd8, 32'h0000_1234);
        settle();
        for (int i = 0; i < 3; i++) begin
            pin(i, "reset", 0, 0, 32'h0000_1234);
            chk($sformatf("reset.cnt[%0d]", i), 32'(o_cnt[i]), 32'd0);
        end
        rst_n = 1'b1;
        tick();

        // Live load hit; entry 1 also holds rd8 (0xAAAA) but source 0 is younger
        drv(1, 1, 5'd8, 32'hDEAD_BEEF, 1, 5'd8, 32'h1);
        settle();
        for (int i = 0; i < 3; i++) pin(i, "live", 1, 0, 32'hDEAD_BEEF);
        tick();

        drv(1, 1, 5'd0, 32'hDEAD_BEEF, 1, 5'd0, 32'h1);
        settle();
        for (int i = 0; i < 3; i++) pin(i, "r0", 0, 0, 32'h1);
        tick();

        flush = 1'b1; drv(0, 0, 5'd0, 0, 0, 5'd0, 0);
        tick();
        flush = 1'b0;
        drv(1, 1, 5'd9, 32'h11, 0, 5'd0, 0);
        tick();
        drv(1, 1, 5'd9, 32'h22, 0, 5'd0, 0);
        tick();
        drv(0, 0, 5'd0, 0, 1, 5'd9, 32'h5);
        settle();
        pin(0, "hist1", 1, 1, 32'h22);
        pin(1, "hist1", 1, 1, 32'h22);
        pin(2, "hist1", 0, 0, 32'h5);
        tick();
        settle();
        pin(0, "hist2", 1, 2, 32'h22);
        pin(1, "hist2", 1, 2, 32'h22);
        tick();
        settle();
        pin(0, "hist3", 0, 0, 32'h5);
        pin(1, "hist3", 1, 3, 32'h22);
        tick();

        // LOAD_ONLY filter: non-load writeback
        drv(1, 0, 5'd5, 32'h55, 1, 5'd5, 32'h7);
        settle();
        pin(0, "lo", 0, 0, 32'h7);
        pin(1, "lo", 1, 0, 32'h55);
        pin(2, "lo", 0, 0, 32'h7);
        tick();

        flush = 1'b1; drv(0, 0, 5'd0, 0, 0, 5'd0, 0);
        tick();
        flush = 1'b0;
        drv(1, 1, 5'd3, 32'h33, 0, 5'd0, 0);
        tick();
        stall = 1'b1;
        drv(0, 0, 5'd0, 0, 1, 5'd3, 32'h0);
        cnt0 = m_cnt[0];
        for (int n = 0; n < 4; n++) begin
            settle();
            pin(0, "stall", 1, 1, 32'h33);
            pin(1, "stall", 1, 1, 32'h33);
            tick();
        end
        chk("stall.cnt_hold", 32'(cnt_a), 32'(cnt0));
        stall = 1'b0; flush = 1'b1;
        settle();
        pin(0, "flushcyc", 1, 1, 32'h33);
        tick();
        flush = 1'b0;
        settle();
        pin(0, "postflush", 0, 0, 32'h0);
        pin(1, "postflush", 0, 0, 32'h0);
        tick();

        // Async reset mid-cycle, then saturation on the 2-bit counter
        drv(1, 1, 5'd4, 32'h44, 1, 5'd4, 32'h99);
        settle();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            pin(i, "arst", 0, 0, 32'h99);
            chk($sformatf("arst.cnt[%0d]", i), 32'(o_cnt[i]), 32'd0);
        end
        tick();
        settle();
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) tick();
        chk("sat.cnt_c", 32'(cnt_c), 32'd3);
        chk("sat.cnt_a", 32'(cnt_a), 32'd5);
        chk("sat.cnt_b", 32'(cnt_b), 32'd5);
        settle();
        rst_n = 1'b0;
        #1;
        chk("arst2.cnt_c", 32'(cnt_c), 32'd0);
        chk("arst2.cnt_a", 32'(cnt_a), 32'd0);
        chk("arst2.fwd_a", 32'(o_fw[0]), 32'd0);
        tick();
        settle();
        rst_n = 1'b1;
        tick();

        for (int n = 0; n < 3000; n++) begin
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(299) == 0) rst_n = 1'b0;
            stall   = ($urandom_range(7) == 0);
            flush   = ($urandom_range(15) == 0);
            wr      = ($urandom_range(3) != 0);
            mr      = $urandom_range(1) == 1;
            wb_rd   = 5'($urandom_range(3));
            wb_data = $urandom;
            mw      = ($urandom_range(3) != 0);
            rt      = 5'($urandom_range(3));
            rtd     = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
